// File: rtl/tc_fetch_sequencer.sv
// tc_fetch_sequencer: instruction fetch sequencer for a registered-output
// program-word ROM (1-cycle read latency, 4 words per read).
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   address       - ROM fetch address (combinational next pc)
//   inst_valid    - ROM outputs hold the instruction at inst_pc
//   inst_pc       - address of the instruction at the ROM outputs
//   step_len      - words consumed by the current instruction (1..4 legal)
//   stall         - consumer not accepting the current instruction
//   jump          - redirect fetch to jump_target
//   jump_target   - redirect address
//   halt          - current instruction is final; stop fetching
//   resume        - leave HALT
//   retire_count  - instructions consumed since reset
//   bad_step      - sticky flag: an illegal step_len was consumed
//   state         - FSM state (PRIME=0, RUN=1, HALT=2)
module tc_fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic [2:0]            step_len,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  halt,
  input  logic                  resume,
  output logic [31:0]           retire_count,
  output logic                  bad_step,
  output logic [1:0]            state
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bad_q, bad_d;
  logic                    valid_c;
  logic                    consume_c;
  logic [2:0]              eff_step_c;

  // A zero step is a non-consume; oversize steps clamp to a full ROM read.
  assign consume_c  = !stall && (step_len != 3'd0);
  assign eff_step_c = (step_len > 3'd4) ? 3'd4 : step_len;

  // Next-state, next-pc and counter logic.
  always_comb begin
    state_d = ST_PRIME;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    valid_c = 1'b0;
    unique case (state_q)
      ST_PRIME: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
        valid_c = 1'b1;
        if (consume_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (step_len > 3'd4) begin
            bad_d = 1'b1;
          end
          pc_d = jump ? jump_target : pc_q + ADDR_WIDTH'(eff_step_c);
          if (halt) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        if (resume) begin
          state_d = ST_RUN;
          if (jump) begin
            pc_d = jump_target;
          end
        end
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PRIME;
      pc_q    <= RESET_ADDR;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  // ROM samples the value pc will load, so its outputs line up with inst_pc.
  assign address      = rst ? RESET_ADDR : pc_d;
  assign inst_valid   = valid_c & ~rst;
  assign inst_pc      = pc_q;
  assign retire_count = cnt_q;
  assign bad_step     = bad_q;
  assign state        = 2'(state_q);

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// Testbench for tc_fetch_sequencer: directed stimulus, behavioural model
// compared every cycle, plus literal spot checks.
module tb_tc_fetch_sequencer;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          inst_valid;
  logic [AW-1:0] inst_pc;
  logic [2:0]    step_len;
  logic          stall;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic          halt;
  logic          resume;
  logic [31:0]   retire_count;
  logic          bad_step;
  logic [1:0]    state;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  tc_fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_ADDR(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .inst_valid   (inst_valid),
    .inst_pc      (inst_pc),
    .step_len     (step_len),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
    .resume       (resume),
    .retire_count (retire_count),
    .bad_step     (bad_step),
    .state        (state)
  );

  // Model: mode 0=bubble after reset, 1=running, 2=halted.
  logic [AW-1:0] m_pc;
  int            m_mode;
  logic [31:0]   m_cnt;
  logic          m_bad;

  function automatic bit m_takes();
    return (m_mode == 1) && !stall && (step_len != 3'd0);
  endfunction

  function automatic logic [AW-1:0] m_step_pc();
    int s;
    s = int'(step_len);
    if (s > 4) s = 4;
    return AW'((int'(m_pc) + s) % 65536);
  endfunction

  function automatic logic [AW-1:0] m_next_pc();
    if (m_takes()) return jump ? jump_target : m_step_pc();
    if (m_mode == 2 && resume && jump) return jump_target;
    return m_pc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc   <= 16'h0000;
      m_mode <= 0;
      m_cnt  <= 32'd0;
      m_bad  <= 1'b0;
    end else begin
      m_pc <= m_next_pc();
      if (m_mode == 0) m_mode <= 1;
      else if (m_mode == 2 && resume) m_mode <= 1;
      if (m_takes()) begin
        m_cnt <= m_cnt + 32'd1;
        if (step_len > 3'd4) m_bad <= 1'b1;
        if (halt) m_mode <= 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_inst_pc",  32'(inst_pc),      32'(m_pc));
      chk("m_valid",    32'(inst_valid),   32'(!rst && m_mode == 1));
      chk("m_state",    32'(state),        32'(m_mode));
      chk("m_count",    retire_count,      m_cnt);
      chk("m_bad_step", 32'(bad_step),     32'(m_bad));
      chk("m_address",  32'(address),      rst ? 32'h0 : 32'(m_next_pc()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; step_len = 3'd2; stall = 1'b0; jump = 1'b0;
    jump_target = 16'h0000; halt = 1'b0; resume = 1'b0;
    cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc",    32'(inst_pc), 32'h0);
    chk("rst_cnt",   retire_count, 32'd0);
    chk("rst_bad",   32'(bad_step), 32'd0);

    // Free run with step 2 after the priming bubble.
    cyc();
    chk("run_pc0",   32'(inst_pc), 32'h0);
    chk("run_valid", 32'(inst_valid), 32'd1);
    cyc(); chk("run_pc2", 32'(inst_pc), 32'h2);
    cyc(); chk("run_pc4", 32'(inst_pc), 32'h4);
    cyc();
    chk("run_pc6",  32'(inst_pc), 32'h6);
    chk("run_cnt3", retire_count, 32'd3);

    // Stall masks jump; release takes the jump.
    jump = 1'b1; jump_target = 16'h0010;
    cyc();
    chk("jmp_pc10", 32'(inst_pc), 32'h10);
    stall = 1'b1; jump_target = 16'h0100;
    repeat (3) cyc();
    chk("stall_pc",  32'(inst_pc), 32'h10);
    chk("stall_cnt", retire_count, 32'd4);
    stall = 1'b0;
    cyc();
    chk("jmp_pc100", 32'(inst_pc), 32'h100);
    chk("jmp_valid", 32'(inst_valid), 32'd1);

    // Address wrap.
    jump_target = 16'hFFFE;
    cyc();
    jump = 1'b0; step_len = 3'd3;
    cyc();
    chk("wrap_pc", 32'(inst_pc), 32'h1);

    // Clamped step and zero step.
    jump = 1'b1; jump_target = 16'h0020; step_len = 3'd2;
    cyc();
    jump = 1'b0; step_len = 3'd6;
    cyc();
    chk("clamp_pc",  32'(inst_pc), 32'h24);
    chk("clamp_bad", 32'(bad_step), 32'd1);
    step_len = 3'd0;
    cyc();
    chk("zero_pc",  32'(inst_pc), 32'h24);
    chk("zero_cnt", retire_count, 32'd9);
    step_len = 3'd1;
    cyc();
    chk("sticky_bad", 32'(bad_step), 32'd1);

    // Halt, ignored jump, resume with jump.
    jump = 1'b1; jump_target = 16'h0040;
    cyc();
    jump = 1'b0; halt = 1'b1; step_len = 3'd1;
    cyc();
    chk("halt_state", 32'(state), 32'd2);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    chk("halt_pc",    32'(inst_pc), 32'h41);
    chk("halt_cnt",   retire_count, 32'd12);
    halt = 1'b0; jump = 1'b1; jump_target = 16'h0099;
    cyc();
    chk("halt_nojmp", 32'(inst_pc), 32'h41);
    resume = 1'b1; jump_target = 16'h0080;
    cyc();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_pc",    32'(inst_pc), 32'h80);
    resume = 1'b0; jump = 1'b0; step_len = 3'd4;
    cyc();
    chk("step4_pc", 32'(inst_pc), 32'h84);

    // Halt combined with jump, then reset while halted with jump pending.
    halt = 1'b1; jump = 1'b1; jump_target = 16'h0050; step_len = 3'd5;
    cyc();
    chk("hj_pc", 32'(inst_pc), 32'h50);
    halt = 1'b0; rst = 1'b1; jump_target = 16'h0077; resume = 1'b1;
    cyc();
    rst = 1'b0; jump = 1'b0; resume = 1'b0;
    chk("hrst_pc",    32'(inst_pc), 32'h0);
    chk("hrst_state", 32'(state), 32'd0);
    chk("hrst_cnt",   retire_count, 32'd0);
    chk("hrst_bad",   32'(bad_step), 32'd0);

    // Reset while running.
    step_len = 3'd2;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rrst_state", 32'(state), 32'd0);
    chk("rrst_pc",    32'(inst_pc), 32'h0);
    cyc(); cyc(); cyc();
    chk("rrst_cnt", retire_count, 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tc_fetch_sequencer.md
TC_FETCH_SEQUENCER -- requirements
Module: tc_fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, program-word address width.
REQ-002 SHALL have parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port address  output  ADDR_WIDTH  fetch address driven to program-word ROM (registered-output ROM, 1-cycle read latency, 4 consecutive words per read).
REQ-006 SHALL have port inst_valid  output  1  ROM outputs this cycle hold the instruction at inst_pc.
REQ-007 SHALL have port inst_pc  output  ADDR_WIDTH  address of the instruction currently at ROM outputs.
REQ-008 SHALL have port step_len  input  3  words consumed by current instruction (legal 1..4).
REQ-009 SHALL have port stall  input  1  consumer not accepting current instruction.
REQ-010 SHALL have port jump  input  1  redirect fetch to jump_target.
REQ-011 SHALL have port jump_target  input  ADDR_WIDTH  redirect address.
REQ-012 SHALL have port halt  input  1  current instruction is final; stop fetching.
REQ-013 SHALL have port resume  input  1  leave HALT.
REQ-014 SHALL have port retire_count  output  32  instructions consumed since reset.
REQ-015 SHALL have port bad_step  output  1  sticky: illegal step_len consumed.
REQ-016 SHALL have port state  output  2  FSM state: PRIME=0, RUN=1, HALT=2.

Function
REQ-017 SHALL hold pc register; inst_pc SHALL equal pc.
REQ-018 SHALL drive address combinationally as pc_next so the ROM samples the same value pc loads; ROM outputs in cycle n+1 then match inst_pc.
REQ-019 PRIME: inst_valid=0, pc_next=pc; next state RUN unconditionally (one bubble while ROM loads).
REQ-020 RUN: inst_valid=1; consume = !stall; stall=1 SHALL hold pc and ignore jump, halt, step_len.
REQ-021 RUN consume, jump=0, halt=0: pc_next = pc + eff_step, modulo 2^ADDR_WIDTH (wrap 0xFFFF+1 -> 0x0000).
REQ-022 eff_step: step_len 1..4 as is; 0 => treated as stall (no consume, no count); 5..7 => clamped to 4 and bad_step set.
REQ-023 RUN consume, jump=1: pc_next = jump_target, no bubble; step_len ignored except for bad_step check.
REQ-024 RUN consume, halt=1: state -> HALT; pc_next = jump_target if jump=1 else pc + eff_step.
REQ-025 HALT: inst_valid=0, pc_next=pc (ROM keeps reading pc); resume=1 -> RUN next cycle; jump=1 with resume loads jump_target first; jump without resume ignored.
REQ-026 retire_count SHALL increment by 1 per consumed instruction (including halting one), wrapping at 2^32.
REQ-027 state encoding 3 unused; SHALL recover to PRIME on next edge.

Reset
REQ-028 Sampled rst=1 SHALL set pc=RESET_ADDR, state=PRIME, retire_count=0, bad_step=0; overrides all other inputs, including mid-jump or in HALT.
REQ-029 While rst=1, address SHALL equal RESET_ADDR and inst_valid=0.
REQ-030 Reset output values: inst_pc=RESET_ADDR, inst_valid=0, state=0, retire_count=0, bad_step=0.

Verification
REQ-031 rst 1 cycle, then step_len=2 free-run -> cycle1 inst_valid=0/state=PRIME; then inst_pc 0,2,4,6 on consecutive cycles, retire_count 1,2,3.
REQ-032 pc=0x0010, stall=1 for 3 cycles with jump=1 -> inst_pc stays 0x0010, retire_count unchanged; release stall, jump_target=0x0100 -> next inst_pc=0x0100, inst_valid stays 1.
REQ-033 pc=0xFFFE, step_len=3 -> next inst_pc=0x0001.
REQ-034 step_len=6 at pc=0x0020 -> next pc=0x0024, bad_step=1 and stays 1; step_len=0 -> pc held, count unchanged.
REQ-035 halt=1 at pc=0x0040, step_len=1 -> state HALT, inst_valid=0, inst_pc=0x0041, retire_count+1; resume with jump to 0x0080 -> next cycle RUN, inst_pc=0x0080.
REQ-036 rst asserted in HALT with jump=1 -> next cycle inst_pc=RESET_ADDR, state PRIME, counters cleared.
